// File: rtl/iob_ram_pkg.sv
// iob_ram_pkg: shared definitions for the iob_ram family.
//   - FSM state encodings for the clear engine
//   - read-during-write mode constants
//   - nbytes(): byte lanes per word
package iob_ram_pkg;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam bit RDW_READ_FIRST  = 1'b0;
  localparam bit RDW_WRITE_FIRST = 1'b1;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_ram_clr_fsm.sv
// iob_ram_clr_fsm: clear engine for iob_ram_tdp_be.
// Owns the RESET/CLEAR/READY state, the clear address counter and the
// port-A write mux: while clearing, port A writes CLR_VAL to clr_cnt,
// otherwise it carries the user's request (gated by ready).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr_i               clear request pulse (honoured only in READY)
//   enA_i/weA_i/addrA_i/dinA_i  user port-A request
//   ready_o             high in READY
//   wea_o/addra_o/dina_o  effective port-A write into the array
module iob_ram_clr_fsm
  import iob_ram_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 10,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter bit                CLR_ON_RST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        enA_i,
  input  logic [nbytes(DATA_W)-1:0]   weA_i,
  input  logic [ADDR_W-1:0]           addrA_i,
  input  logic [DATA_W-1:0]           dinA_i,
  output logic                        ready_o,
  output logic [nbytes(DATA_W)-1:0]   wea_o,
  output logic [ADDR_W-1:0]           addra_o,
  output logic [DATA_W-1:0]           dina_o
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clearing;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_RESET: state_d = CLR_ON_RST ? ST_CLEAR : ST_READY;
      ST_CLEAR: begin
        // counter wraps to 0 on the last address, ready for the next clear
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) state_d = ST_READY;
      end
      ST_READY: if (clr_i) state_d = ST_CLEAR;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ready_o  = (state_q == ST_READY);
  assign clearing = (state_q == ST_CLEAR);

  assign wea_o   = clearing ? '1 : ((ready_o && enA_i) ? weA_i : '0);
  assign addra_o = clearing ? clr_cnt_q : addrA_i;
  assign dina_o  = clearing ? CLR_VAL : dinA_i;

endmodule

// File: rtl/iob_ram_tdp_be.sv
// iob_ram_tdp_be: single-clock true-dual-port RAM with byte enables,
// selectable read-during-write, optional output register and clear engine.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   clr / ready              start a clear / ports accept requests
//   enX, weX, addrX, dinX    port X request (weX all-zero = read)
//   doutX, rvalidX           port X read data and its valid strobe
// Internally port index 0 is A, 1 is B.
module iob_ram_tdp_be
  import iob_ram_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 10,
  parameter bit                WRITE_FIRST = RDW_READ_FIRST,
  parameter bit                OUT_REG     = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VAL     = '0,
  parameter bit                CLR_ON_RST  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  output logic                      ready,
  input  logic                      enA,
  input  logic [nbytes(DATA_W)-1:0] weA,
  input  logic [ADDR_W-1:0]         addrA,
  input  logic [DATA_W-1:0]         dinA,
  output logic [DATA_W-1:0]         doutA,
  output logic                      rvalidA,
  input  logic                      enB,
  input  logic [nbytes(DATA_W)-1:0] weB,
  input  logic [ADDR_W-1:0]         addrB,
  input  logic [DATA_W-1:0]         dinB,
  output logic [DATA_W-1:0]         doutB,
  output logic                      rvalidB
);

  localparam int NB    = nbytes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NB-1:0]     wea_w, web_w;
  logic [ADDR_W-1:0] addra_w;
  logic [DATA_W-1:0] dina_w;
  logic [1:0]        acc;

  iob_ram_clr_fsm #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLR_VAL(CLR_VAL), .CLR_ON_RST(CLR_ON_RST)
  ) u_clr_fsm (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .enA_i(enA), .weA_i(weA), .addrA_i(addrA), .dinA_i(dinA),
    .ready_o(ready), .wea_o(wea_w), .addra_o(addra_w), .dina_o(dina_w)
  );

  assign web_w = (ready && enB) ? weB : '0;
  assign acc   = {ready & enB, ready & enA};

  // Array has no reset; contents are defined only after a clear.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (web_w[i]) mem[addrB][i*8 +: 8] <= dinB[i*8 +: 8];
      // A is assigned last so it wins on lanes both ports enable
      if (wea_w[i]) mem[addra_w][i*8 +: 8] <= dina_w[i*8 +: 8];
    end
  end

  // Read data; in write-first mode, overlay this cycle's writes from both
  // ports (A over B) so the reader sees the final merged word.
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rd;
  assign raddr = {addrB, addrA};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem[raddr[p]];
      if (WRITE_FIRST == RDW_WRITE_FIRST) begin
        for (int i = 0; i < NB; i++) begin
          if (web_w[i] && (addrB == raddr[p]))   rd[p][i*8 +: 8] = dinB[i*8 +: 8];
          if (wea_w[i] && (addra_w == raddr[p])) rd[p][i*8 +: 8] = dina_w[i*8 +: 8];
        end
      end
    end
  end

  // Stage 1: data only loads on an accepted request, so dout holds otherwise.
  logic [1:0]             vld_s1_q;
  logic [1:0][DATA_W-1:0] dat_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1_q <= '0;
      dat_s1_q <= '0;
    end else begin
      vld_s1_q <= acc;
      for (int p = 0; p < 2; p++)
        if (acc[p]) dat_s1_q[p] <= rd[p];
    end
  end

  if (OUT_REG) begin : g_oreg
    logic [1:0]             vld_s2_q;
    logic [1:0][DATA_W-1:0] dat_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_s2_q <= '0;
        dat_s2_q <= '0;
      end else begin
        vld_s2_q <= vld_s1_q;
        for (int p = 0; p < 2; p++)
          if (vld_s1_q[p]) dat_s2_q[p] <= dat_s1_q[p];
      end
    end

    assign {rvalidB, rvalidA} = vld_s2_q;
    assign doutA = dat_s2_q[0];
    assign doutB = dat_s2_q[1];
  end else begin : g_noreg
    assign {rvalidB, rvalidA} = vld_s1_q;
    assign doutA = dat_s1_q[0];
    assign doutB = dat_s1_q[1];
  end

endmodule

// File: tb/tb_iob_ram_tdp_be.sv
// Two instances share all inputs:
//   u0: read-first, no output register, clear on reset
//   u1: write-first, output register, no clear on reset
module tb_iob_ram_tdp_be;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic        enA = 1'b0, enB = 1'b0;
  logic [3:0]  weA = '0, weB = '0, addrA = '0, addrB = '0;
  logic [31:0] dinA = '0, dinB = '0;

  logic        ready0, ready1, rvA0, rvB0, rvA1, rvB1;
  logic [31:0] dA0, dB0, dA1, dB1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_ram_tdp_be #(
    .DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1'b0), .OUT_REG(1'b0),
    .CLR_VAL(CV), .CLR_ON_RST(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready0),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(dA0), .rvalidA(rvA0),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(dB0), .rvalidB(rvB0)
  );

  iob_ram_tdp_be #(
    .DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1'b1), .OUT_REG(1'b1),
    .CLR_VAL(CV), .CLR_ON_RST(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready1),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(dA1), .rvalidA(rvA1),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(dB1), .rvalidB(rvB1)
  );

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    enA = 1'b0; enB = 1'b0; weA = '0; weB = '0; clr = 1'b0;
  endtask

  // Steps negedges until u0 is ready; counts rvalid pulses seen meanwhile.
  task automatic wait_rdy(input bit both, output int n, output int rv);
    n = 0; rv = 0;
    do begin
      @(negedge clk);
      n++;
      rv += int'(rvA0) + int'(rvB0);
      if (both) rv += int'(rvA1) + int'(rvB1);
    end while (!ready0 && n < 40);
  endtask

  // Single read on port p; u0 answers after one edge, u1 after two.
  task automatic rd(input string tag, input bit p, input logic [3:0] a,
                    input logic [31:0] e0, input logic [31:0] e1);
    if (p) begin enB = 1'b1; weB = '0; addrB = a; end
    else   begin enA = 1'b1; weA = '0; addrA = a; end
    @(negedge clk);
    idle();
    chk({tag, "_u0"}, p ? {rvB0, dB0} : {rvA0, dA0}, {1'b1, e0});
    @(negedge clk);
    chk({tag, "_u1"}, p ? {rvB1, dB1} : {rvA1, dA1}, {1'b1, e1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rv, rv0, rv1;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready0, ready1}, '0);
    chk("rst_doutA0", {rvA0, dA0}, '0);
    chk("rst_doutB1", {rvB1, dB1}, '0);

    // Power-up clear with requests held on; u0 must ignore them.
    rst_n = 1'b1; enA = 1'b1; enB = 1'b1; addrA = 4'd1; addrB = 4'd2;
    wait_rdy(1'b0, n, rv);
    chk("pwr_clr_len", 33'(n - 1), 33'd16);
    chk("pwr_clr_rv", 33'(rv), '0);
    chk("pwr_rdy1", {32'd0, ready1}, 33'd1);
    idle();
    repeat (3) @(negedge clk);

    // Joint runtime clear so both instances hold CLR_VAL.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; enA = 1'b1; enB = 1'b1;
    wait_rdy(1'b1, n, rv);
    chk("rt_clr_len", 33'(n), 33'd16);
    chk("rt_clr_rv", 33'(rv), '0);
    idle();
    for (int i = 0; i < 16; i++) begin
      rd("clrA", 1'b0, 4'(i), CV, CV);
      rd("clrB", 1'b1, 4'(i), CV, CV);
    end

    // Byte enables.
    enA = 1'b1; weA = 4'b0101; addrA = 4'd3; dinA = 32'h11223344;
    @(negedge clk);
    idle();
    rd("be", 1'b1, 4'd3, 32'hA522A544, 32'hA522A544);

    // Write-write collision.
    enA = 1'b1; weA = 4'b0011; addrA = 4'd7; dinA = 32'hAAAAAAAA;
    enB = 1'b1; weB = 4'b0110; addrB = 4'd7; dinB = 32'hBBBBBBBB;
    @(negedge clk);
    idle();
    rd("ww", 1'b0, 4'd7, 32'hA5BBAAAA, 32'hA5BBAAAA);

    // Cross-port and same-port read-during-write.
    enA = 1'b1; weA = 4'b1111; addrA = 4'd2; dinA = 32'hDEADBEEF;
    enB = 1'b1; weB = 4'b0000; addrB = 4'd2;
    @(negedge clk);
    idle();
    chk("rdw_B_u0", {rvB0, dB0}, {1'b1, CV});
    chk("rdw_A_u0", {rvA0, dA0}, {1'b1, CV});
    @(negedge clk);
    chk("rdw_B_u1", {rvB1, dB1}, {1'b1, 32'hDEADBEEF});
    chk("rdw_A_u1", {rvA1, dA1}, {1'b1, 32'hDEADBEEF});
    chk("hold_B_u0", {rvB0, dB0}, {1'b0, CV});
    enA = 1'b1; weA = 4'b0011; addrA = 4'd9; dinA = 32'h12345678;
    @(negedge clk);
    idle();
    chk("rdwp_u0", {rvA0, dA0}, {1'b1, CV});
    @(negedge clk);
    chk("rdwp_u1", {rvA1, dA1}, {1'b1, 32'hA5A55678});
    rd("rdw_rd2", 1'b1, 4'd2, 32'hDEADBEEF, 32'hDEADBEEF);
    rd("rdw_rd9", 1'b1, 4'd9, 32'hA5A55678, 32'hA5A55678);

    // Fill with index, then back-to-back reads on both ports.
    for (int i = 0; i < 16; i++) begin
      enA = 1'b1; weA = 4'b1111; addrA = 4'(i); dinA = 32'(i);
      @(negedge clk);
    end
    idle();
    rv0 = 0; rv1 = 0;
    for (int k = 0; k < 18; k++) begin
      if (k >= 1) rv0 += int'(rvA0) + int'(rvB0);
      if (k >= 2) rv1 += int'(rvA1) + int'(rvB1);
      if (k >= 1 && k <= 16) begin
        chk("tpA_u0", {rvA0, dA0}, {1'b1, 32'(k - 1)});
        chk("tpB_u0", {rvB0, dB0}, {1'b1, 32'(16 - k)});
      end
      if (k >= 2) begin
        chk("tpA_u1", {rvA1, dA1}, {1'b1, 32'(k - 2)});
        chk("tpB_u1", {rvB1, dB1}, {1'b1, 32'(17 - k)});
      end
      if (k < 16) begin
        enA = 1'b1; addrA = 4'(k); enB = 1'b1; addrB = 4'(15 - k);
      end else begin
        idle();
      end
      @(negedge clk);
    end
    chk("tp_cnt_u0", 33'(rv0), 33'd32);
    chk("tp_cnt_u1", 33'(rv1), 33'd32);

    // Runtime clear aborted by reset after addresses 0-4 are written.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready0, ready1}, '0);
    chk("abort_doutA0", {rvA0, dA0}, '0);
    chk("abort_doutA1", {rvA1, dA1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rdy1", {31'd0, ready0, ready1}, 33'd1);
    wait_rdy(1'b0, n, rv);
    chk("abort_clr_len", 33'(n), 33'd16);
    for (int i = 0; i < 16; i++)
      rd("abort_rd", 1'b0, 4'(i), CV, (i < 5) ? CV : 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_ram_tdp_be.md
# iob_ram_tdp_be

Single-clock true-dual-port RAM with per-port byte enables, a selectable read-during-write mode, an optional output register stage, and a built-in clear engine. On reset, and on request, the clear engine fills every word with a constant. This block replaces the plain dual-clock TDP RAM wherever both ports share one clock, for example Versat configuration and data memories that must power up in a known state. Each port has a read-valid strobe, so consumers need no external latency tracking.

## Interface
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `ADDR_W`, default 10: address width; depth is 2**ADDR_W.
- `WRITE_FIRST`, default 0: read-during-write mode.
  - 0: a read returns the old data.
  - 1: a read returns the newly written data.
- `OUT_REG`, default 0: adds one output register stage when set to 1.
- `CLR_VAL`, default 0: `DATA_W`-bit constant written by the clear engine.
- `CLR_ON_RST`, default 1: when 1, a clear runs automatically after reset.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clr` input, 1 bit: single-cycle pulse that starts a clear; honoured only in READY.
- `ready` output, 1 bit: high when ports accept requests.
- `enA`/`enB` input, 1 bit: request on port A/B.
- `weA`/`weB` input, `DATA_W/8` bits: byte write enables. All-zero means a read.
- `addrA`/`addrB` input, `ADDR_W` bits: word address.
- `dinA`/`dinB` input, `DATA_W` bits: write data.
- `doutA`/`doutB` output, `DATA_W` bits: read data.
- `rvalidA`/`rvalidB` output, 1 bit: `dout` is valid this cycle.

## Operation
- FSM states:
  - RESET: held while `rst_n` is low.
  - CLEAR: walks `clr_cnt` from 0 to 2**ADDR_W-1, writing `CLR_VAL` to one word per cycle.
  - READY: normal operation.
- FSM transitions:
  - On `rst_n` rising, go to CLEAR if `CLR_ON_RST`=1, otherwise to READY.
  - CLEAR goes to READY after the cycle that writes the last address; `clr_cnt` wraps to 0.
  - READY goes to CLEAR when `clr` is high.
- `ready`=1 only in READY.
  - In RESET and CLEAR, `en*` is ignored: no write, no `rvalid`, `dout` holds its value.
  - A request in the same cycle that `clr` is accepted is served. The clear starts on the next cycle.
- Accepted request, per port:
  - Each byte with `we[i]`=1 is written.
  - A read of `addr` is always performed, whatever `we` is.
  - `rvalid` pulses once per accepted request, including writes.
- Same-port read-during-write:
  - `WRITE_FIRST`=1: `dout` returns the merged word: new bytes where `we[i]`=1, old bytes elsewhere.
  - `WRITE_FIRST`=0: `dout` returns the full old word.
- Cross-port collision (same address, same cycle):
  - Both write: byte lanes enabled on only one port take that port's data. Lanes enabled on both take port A's data.
  - One writes, the other reads: the reader sees the `WRITE_FIRST` semantics above, applied to the final merged word.
- `dout` holds its last value until the next `rvalid`.
- After RESET, `dout` is 0 and RAM contents are undefined until a clear completes.
- Reset asserted mid-clear: the FSM aborts to RESET. The clear restarts from address 0 after release when `CLR_ON_RST`=1. Otherwise contents stay partially cleared.

## Timing
- Read latency from the accepted `en` edge to `dout`/`rvalid`:
  - 1 cycle with `OUT_REG`=0.
  - 2 cycles with `OUT_REG`=1.
- Fully pipelined: one request per port per cycle, no stalls in READY.
- A write is visible to a read on either port issued in the next cycle.
- Clear duration is exactly 2**ADDR_W cycles. `ready` rises in the cycle after the last clear write.
- Reset values: `ready`=0, `doutA`=`doutB`=0, `rvalidA`=`rvalidB`=0, `clr_cnt`=0, FSM=RESET.
- With `OUT_REG`=1, both pipeline stages reset to 0. An abort mid-pipeline drops in-flight `rvalid`s.

## Structure
- Shared package `iob_ram_pkg`:
  - FSM state encodings: `ST_RESET`, `ST_CLEAR`, `ST_READY`.
  - Mode constants: `RDW_READ_FIRST`=0, `RDW_WRITE_FIRST`=1.
  - Function `nbytes(DATA_W)`.
- Sub-module `iob_ram_clr_fsm`: the FSM, `clr_cnt`, `ready`, and the muxing of clear writes onto port A.
- The top level holds:
  - the memory array;
  - byte-lane collision merge;
  - read-during-write bypass;
  - the `OUT_REG` stage;
  - the `rvalid` shift registers.
- Target size is about 200–300 RTL lines.

## Test plan
All scenarios use `DATA_W`=32, `ADDR_W`=4, `CLR_VAL`=0xA5A5A5A5.

1. Power-up clear: release `rst_n` → `ready` stays 0 for 16 cycles, then rises. Reads of addresses 0–15 on both ports return 0xA5A5A5A5. `en` asserted during the clear produces no `rvalid`.
2. Byte enables: A writes 0x11223344 with `we`=0b0101 to address 3. B reads address 3 the next cycle → 0xA522A544 with `rvalidB` one cycle later (`OUT_REG`=0) or two cycles later (`OUT_REG`=1).
3. Write-write collision at address 7:
   - A writes 0xAAAAAAAA with `we`=0b0011; B writes 0xBBBBBBBB with `we`=0b0110.
   - A read of address 7 → 0xA5BBAAAA.
4. Read-during-write: A writes 0xDEADBEEF to address 2 (old value 0xA5A5A5A5) while B reads address 2.
   - `WRITE_FIRST`=0 → `doutB`=0xA5A5A5A5.
   - `WRITE_FIRST`=1 → `doutB`=0xDEADBEEF.
5. Runtime clear and abort:
   - Fill addresses 0–15 with their index, pulse `clr`, and drop `rst_n` at `clr_cnt`=5.
   - With `CLR_ON_RST`=0 → `ready`=1 after release, addresses 0–4 read 0xA5A5A5A5, addresses 5–15 read their index.
6. Throughput: back-to-back reads on both ports for 16 cycles → 16 `rvalid` pulses per port, in order, with no bubbles.
